pc_seq_unit: RTL and testbench

- Parametrised program-counter sequencer; successor to the single-cycle PC register.
- Holds the fetch address and presents it for STEP_CYCLES clock cycles per instruction (multi-cycle datapath support).
- Selects the next PC by priority: trap > branch redirect > sequential npc. Redirect/trap requests arriving mid-instruction are buffered until the instruction boundary.
- Sits between next-PC logic and instruction fetch; next_iter tells the datapath that a new instruction begins.

---
 rtl/pc_seq_unit.sv | 135 +++++++++++++
 tb/tb_pc_seq_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: holds the fetch address for STEP_CYCLES cycles per instruction
// and selects the next PC at the instruction boundary (trap > redirect > sequential).
module pc_seq_unit #(
    parameter int unsigned         XLEN         = 32,
    parameter logic [XLEN-1:0]     RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]     TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned         STEP_CYCLES  = 1,
    parameter int unsigned         ALIGN_BITS   = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic [XLEN-1:0] npc_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_i,
    output logic [XLEN-1:0] pc_o,
    output logic            next_iter_o,
    output logic [2:0]      phase_o,
    output logic            exc_misalign_o
);

    typedef enum logic [0:0] {StStart, StRun} state_e;

    localparam logic [2:0]      LastPhase = 3'(STEP_CYCLES - 1);
    localparam logic [XLEN-1:0] AlignMask = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [2:0]      phase_q, phase_d;
    logic            next_iter_q, next_iter_d;
    logic            exc_q, exc_d;
    logic            pend_redir_q, pend_redir_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic            pend_trap_q, pend_trap_d;

    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            last_phase;

    // A same-cycle request outranks a buffered one of the same kind.
    always_comb begin
        if (trap_i || pend_trap_q) begin
            target = TRAP_VECTOR;
        end else if (redirect_valid_i) begin
            target = redirect_target_i;
        end else if (pend_redir_q) begin
            target = pend_tgt_q;
        end else begin
            target = npc_i;
        end
    end

    assign misaligned = ((target & AlignMask) != '0) && (target != TRAP_VECTOR);
    assign last_phase = (phase_q == LastPhase);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StStart;
            pc_q         <= RESET_VECTOR;
            phase_q      <= '0;
            next_iter_q  <= 1'b0;
            exc_q        <= 1'b0;
            pend_redir_q <= 1'b0;
            pend_tgt_q   <= '0;
            pend_trap_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            phase_q      <= phase_d;
            next_iter_q  <= next_iter_d;
            exc_q        <= exc_d;
            pend_redir_q <= pend_redir_d;
            pend_tgt_q   <= pend_tgt_d;
            pend_trap_q  <= pend_trap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStart: state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StStart;
        endcase
    end

    always_comb begin
        pc_d         = pc_q;
        phase_d      = phase_q;
        next_iter_d  = 1'b0;
        exc_d        = 1'b0;
        pend_redir_d = pend_redir_q;
        pend_tgt_d   = pend_tgt_q;
        pend_trap_d  = pend_trap_q;

        unique case (state_q)
            StStart: begin
                // Stall is ignored here so the first instruction always begins.
                phase_d     = '0;
                next_iter_d = 1'b1;
            end
            StRun: begin
                if (!stall_i && last_phase) begin
                    pc_d         = misaligned ? TRAP_VECTOR : target;
                    exc_d        = misaligned;
                    phase_d      = '0;
                    next_iter_d  = 1'b1;
                    pend_redir_d = 1'b0;
                    pend_trap_d  = 1'b0;
                end else begin
                    if (!stall_i) begin
                        phase_d = phase_q + 3'd1;
                    end
                    if (redirect_valid_i) begin
                        pend_redir_d = 1'b1;
                        pend_tgt_d   = redirect_target_i;
                    end
                    if (trap_i) begin
                        pend_trap_d = 1'b1;
                    end
                end
            end
            default: begin
                phase_d = '0;
            end
        endcase
    end

    assign pc_o           = pc_q;
    assign next_iter_o    = next_iter_q;
    assign phase_o        = phase_q;
    assign exc_misalign_o = exc_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: three instances (1, 5 and 3 cycles per instruction) driven in lockstep
// and compared every cycle against an instruction-level reference model.
module tb_pc_seq_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, stall, rv_in, trap_in;
    logic [31:0] rt_in;
    logic [31:0] npc_w [3];
    logic [31:0] pc_w  [3];
    logic [2:0]  ph_w  [3];
    logic        ni_w  [3];
    logic        ex_w  [3];

    int n_checks = 0;
    int n_errors = 0;

    int steps [3] = '{1, 5, 3};

    // Reference model: what each DUT should show after the next edge.
    logic [31:0] m_pc   [3];
    int          m_ph   [3];
    bit          m_ni   [3];
    bit          m_ex   [3];
    bit          m_run  [3];
    bit          m_trap [3];
    logic [31:0] m_req  [3][64];
    int          m_nreq [3];

    always #5 clk = ~clk;

    pc_seq_unit #(.STEP_CYCLES(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .npc_i(npc_w[0]),
        .redirect_valid_i(rv_in), .redirect_target_i(rt_in), .trap_i(trap_in),
        .pc_o(pc_w[0]), .next_iter_o(ni_w[0]), .phase_o(ph_w[0]), .exc_misalign_o(ex_w[0])
    );

    pc_seq_unit #(.STEP_CYCLES(5)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .npc_i(npc_w[1]),
        .redirect_valid_i(rv_in), .redirect_target_i(rt_in), .trap_i(trap_in),
        .pc_o(pc_w[1]), .next_iter_o(ni_w[1]), .phase_o(ph_w[1]), .exc_misalign_o(ex_w[1])
    );

    pc_seq_unit #(.STEP_CYCLES(3)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .npc_i(npc_w[2]),
        .redirect_valid_i(rv_in), .redirect_target_i(rt_in), .trap_i(trap_in),
        .pc_o(pc_w[2]), .next_iter_o(ni_w[2]), .phase_o(ph_w[2]), .exc_misalign_o(ex_w[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input bit r, input bit st, input bit rv,
                              input logic [31:0] rt, input bit tr, input logic [31:0] npc);
        logic [31:0] t;
        if (r) begin
            m_pc[k] = RV; m_ph[k] = 0; m_ni[k] = 0; m_ex[k] = 0;
            m_run[k] = 0; m_trap[k] = 0; m_nreq[k] = 0;
        end else if (!m_run[k]) begin
            m_run[k] = 1; m_ph[k] = 0; m_ni[k] = 1; m_ex[k] = 0;
        end else if (!st && m_ph[k] == steps[k] - 1) begin
            if (tr || m_trap[k])   t = TV;
            else if (rv)           t = rt;
            else if (m_nreq[k] > 0) t = m_req[k][m_nreq[k] - 1];
            else                   t = npc;
            if (t[1:0] != 2'b00 && t != TV) begin
                m_pc[k] = TV; m_ex[k] = 1;
            end else begin
                m_pc[k] = t;  m_ex[k] = 0;
            end
            m_ph[k] = 0; m_ni[k] = 1; m_trap[k] = 0; m_nreq[k] = 0;
        end else begin
            if (!st) m_ph[k] = m_ph[k] + 1;
            m_ni[k] = 0; m_ex[k] = 0;
            if (rv) begin
                if (m_nreq[k] < 64) m_nreq[k]++;
                m_req[k][m_nreq[k] - 1] = rt;
            end
            if (tr) m_trap[k] = 1;
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare at the falling edge.
    task automatic cycle(input bit r, input bit st, input bit rv, input logic [31:0] rt,
                         input bit tr, input int npc_sel);
        rst = r; stall = st; rv_in = rv; rt_in = rt; trap_in = tr;
        for (int k = 0; k < 3; k++) begin
            case (npc_sel)
                1:       npc_w[k] = $urandom;
                2:       npc_w[k] = 32'hFFFF_FFFC;
                default: npc_w[k] = m_pc[k] + 32'd4;
            endcase
            model_step(k, r, st, rv, rt, tr, npc_w[k]);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("pc%0d", k), pc_w[k], m_pc[k]);
            check_eq($sformatf("phase%0d", k), 32'(ph_w[k]), 32'(m_ph[k]));
            check_eq($sformatf("next_iter%0d", k), 32'(ni_w[k]), 32'(m_ni[k]));
            check_eq($sformatf("exc%0d", k), 32'(ex_w[k]), 32'(m_ex[k]));
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic wait_phase2(input int want);
        for (int i = 0; i < 16 && m_ph[2] != want; i++) idle();
    endtask

    initial begin
        logic [31:0] held_pc;
        bit          r, st, rv, tr;
        logic [31:0] rt;

        // Reset then START cycle.
        cycle(1, 0, 0, 32'h0, 0, 0);
        cycle(1, 1, 0, 32'h0, 0, 0);
        check_eq("start_pc", pc_w[0], 32'h0);
        check_eq("start_ni", 32'(ni_w[0]), 32'h0);
        idle();
        check_eq("first_pc", pc_w[0], 32'h0);
        check_eq("first_ni", 32'(ni_w[0]), 32'h1);
        idle(); check_eq("seq_pc4", pc_w[0], 32'h4);
        idle(); check_eq("seq_pc8", pc_w[0], 32'h8);
        idle(); check_eq("seq_pcC", pc_w[0], 32'hC);

        // Buffered redirect on the 3-cycle instance.
        wait_phase2(0);
        cycle(0, 0, 1, 32'h40, 0, 0);
        idle();
        idle();
        check_eq("redir_40", pc_w[2], 32'h40);
        cycle(0, 0, 1, 32'h40, 0, 0);
        cycle(0, 0, 1, 32'h80, 0, 0);
        idle();
        check_eq("redir_80", pc_w[2], 32'h80);

        // Trap beats redirect; misaligned redirect vectors to the trap address.
        wait_phase2(2);
        cycle(0, 0, 1, 32'h40, 1, 0);
        check_eq("trap_pri2", pc_w[2], 32'h100);
        check_eq("trap_pri0", pc_w[0], 32'h100);
        wait_phase2(2);
        cycle(0, 0, 1, 32'h42, 0, 0);
        check_eq("misal_pc", pc_w[2], 32'h100);
        check_eq("misal_exc", 32'(ex_w[2]), 32'h1);
        idle();
        check_eq("misal_exc_clr", 32'(ex_w[2]), 32'h0);

        // Stall mid-instruction with a redirect arriving during the stall.
        wait_phase2(1);
        held_pc = m_pc[2];
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, i == 1, 32'h200, 0, 0);
            check_eq("stall_pc", pc_w[2], held_pc);
            check_eq("stall_ph", 32'(ph_w[2]), 32'h1);
        end
        idle();
        idle();
        check_eq("stall_redir", pc_w[2], 32'h200);

        // Reset while a redirect is pending.
        wait_phase2(1);
        cycle(0, 0, 1, 32'h40, 0, 0);
        cycle(1, 0, 0, 32'h0, 0, 0);
        check_eq("rst_mid_pc", pc_w[2], 32'h0);
        for (int i = 0; i < 4; i++) idle();
        check_eq("rst_mid_seq", pc_w[2], 32'h4);

        // Wraparound npc taken verbatim.
        wait_phase2(2);
        cycle(0, 0, 0, 32'h0, 0, 2);
        check_eq("npc_top", pc_w[2], 32'hFFFF_FFFC);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 99) < 1);
            st = ($urandom_range(0, 99) < 15);
            rv = ($urandom_range(0, 99) < 12);
            tr = ($urandom_range(0, 99) < 4);
            rt = $urandom;
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) rt = TV;
            cycle(r, st, rv, rt, tr, int'($urandom_range(0, 4) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
